gauss3x3_seq_ctrl: RTL and testbench
====================================

GAUSS3X3_SEQ_CTRL -- requirements
Module: gauss3x3_seq_ctrl

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; legal range 3..1023.
REQ-002 Parameter IMG_H, default 8: image height in pixels; legal range 3..1023.
REQ-003 Parameter DP_LAT, default 2: pipeline depth of the approximate-counter filter datapath, in cycles; legal range 1..8.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 start  in  1  one-cycle frame start request; acted on only in IDLE.
REQ-007 approx_mode  in  1  datapath mode request: 1 selects approximate 5:3 counters, 0 selects exact; sampled with start.
REQ-008 pix_valid  in  1  input pixel valid.
REQ-009 pix_ready  out  1  input pixel ready.
REQ-010 out_ready  in  1  downstream accepts filtered pixel.
REQ-011 out_valid  out  1  filtered pixel valid at datapath output.
REQ-012 lb_wr_en  out  1  line-buffer write strobe, one per accepted pixel.
REQ-013 lb_col  out  10  column index of the accepted pixel (line-buffer address).
REQ-014 dp_en  out  1  datapath pipeline-register advance enable.
REQ-015 win_load  out  1  the accepted pixel completes an interior 3x3 window; the datapath captures that window.
REQ-016 approx_sel  out  1  latched mode select driven to every counter column of the datapath.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-019 FSM states: IDLE, FILL, RUN, FLUSH, DONE.
REQ-020 IDLE->FILL on start=1; approx_sel <= approx_mode on the same edge; col and row counters cleared to 0.
REQ-021 start in any state other than IDLE is ignored; approx_sel holds its value until the next accepted start.
REQ-022 pipe_adv = ~out_valid | out_ready; dp_en = pipe_adv in every state.
REQ-023 pix_ready = pipe_adv when in FILL or RUN; pix_ready = 0 in all other states.
REQ-024 Accept = pix_valid & pix_ready; on accept: lb_wr_en=1, lb_col=col (combinational, same cycle).
REQ-025 On accept, col increments; when col=IMG_W-1, col wraps to 0 and row increments.
REQ-026 FILL->RUN on the accept of the pixel at (row=1, col=IMG_W-1).
REQ-027 win_load=1 on accept when row>=2 and col>=2; the window centre is (row-1, col-1); border pixels produce no output.
REQ-028 Valid shift register vsr[DP_LAT-1:0] advances only when pipe_adv=1; vsr[0] <= win_load; out_valid = vsr[DP_LAT-1].
REQ-029 When pipe_adv=0, vsr, col, row and all datapath stages hold; no pixel is accepted.
REQ-030 RUN->FLUSH on the accept of the pixel at (IMG_H-1, IMG_W-1).
REQ-031 FLUSH->DONE when vsr is all zero (last output handshaken).
REQ-032 DONE: frame_done=1 for exactly one cycle, then unconditional transition to IDLE.
REQ-033 Exactly (IMG_W-2)*(IMG_H-2) out_valid handshakes occur per frame, in raster order of window centre.
REQ-034 Input-to-output latency is DP_LAT cycles from win_load with out_ready held high.
REQ-035 pix_valid while pix_ready=0 is ignored, with no counter change.

Reset
REQ-036 rst_n=0 at a clock edge forces: state=IDLE, col=0, row=0, vsr=0, approx_sel=0, frame_done=0.
REQ-037 Reset mid-frame discards all in-flight windows; out_valid=0 on the first cycle after reset.
REQ-038 Reset dominates start on the same edge.
REQ-039 Combinational outputs after reset: pix_ready=0, busy=0, lb_wr_en=0, win_load=0, dp_en=1.

Verification
REQ-040 Configuration IMG_W=4, IMG_H=4, DP_LAT=2; start with approx_mode=1; pix_valid=1; out_ready=1 throughout. Required response: 16 accepts; win_load at pixels 10, 11, 14 and 15; 4 out_valid pulses, each 2 cycles after its win_load; frame_done 3 cycles after the last accept; approx_sel=1.
REQ-041 Same configuration with out_ready held 0 for 5 cycles after the first out_valid. Required response: pix_ready=0 and col, row and vsr frozen during the stall; no output lost or duplicated; 4 outputs in total.
REQ-042 Same configuration with pix_valid toggling 1,0,1,0. Required response: the counters advance only on accepts; win_load positions are unchanged relative to the accepted-pixel count.
REQ-043 Assert rst_n=0 for 1 cycle after the 12th accept. Required response: IDLE, out_valid=0 and busy=0 on the next cycle; a following start runs a clean full frame.
REQ-044 Assert start in RUN with approx_mode=0. Required response: start is ignored; approx_sel stays 1; the frame completes normally.
REQ-045 Configuration IMG_W=3, IMG_H=3, DP_LAT=1. Required response: exactly 1 output, with win_load on the 9th accept.

Source files
------------

// File: rtl/gauss3x3_seq_ctrl.sv
// ============================================================================
// Module   : gauss3x3_seq_ctrl
// Brief    : Frame sequencer for a 3x3 Gaussian filter with an approximate /
//            exact counter datapath. It sequences line-buffer writes, window
//            loads and datapath pipeline enables, and tracks valid outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss3x3_seq_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DP_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       approx_mode,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       lb_wr_en,
  output logic [9:0] lb_col,
  output logic       dp_en,
  output logic       win_load,
  output logic       approx_sel,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [9:0] C_COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] C_ROW_LAST = 10'(IMG_H - 1);

  state_t              state_q;
  logic [9:0]          col_q, col_d;
  logic [9:0]          row_q, row_d;
  logic [DP_LAT-1:0]   vsr_q, vsr_d;
  logic                approx_sel_q;
  logic                frame_done_q;

  logic pipe_adv;
  logic accept;
  logic col_last;
  logic row_last;

  // The whole pipeline, including pixel intake, stalls on a blocked output.
  assign pipe_adv   = ~vsr_q[DP_LAT-1] | out_ready;
  assign pix_ready  = pipe_adv & ((state_q == S_FILL) | (state_q == S_RUN));
  assign accept     = pix_valid & pix_ready;
  assign col_last   = (col_q == C_COL_LAST);
  assign row_last   = (row_q == C_ROW_LAST);
  assign win_load   = accept & (row_q >= 10'd2) & (col_q >= 10'd2);

  assign out_valid  = vsr_q[DP_LAT-1];
  assign lb_wr_en   = accept;
  assign lb_col     = col_q;
  assign dp_en      = pipe_adv;
  assign approx_sel = approx_sel_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = 10'd0;
        row_d = row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_comb begin
    vsr_d = vsr_q;
    if (pipe_adv) begin
      vsr_d[0] = win_load;
      for (int i = 1; i < DP_LAT; i++) begin
        vsr_d[i] = vsr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= 10'd0;
      row_q        <= 10'd0;
      vsr_q        <= '0;
      approx_sel_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      vsr_q        <= vsr_d;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_FILL;
            approx_sel_q <= approx_mode;
            col_q        <= 10'd0;
            row_q        <= 10'd0;
          end
        end
        S_FILL: begin
          if (accept && (row_q == 10'd1) && col_last) state_q <= S_RUN;
        end
        S_RUN: begin
          if (accept && row_last && col_last) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          // Leave as soon as the last valid output is being handshaken.
          if (vsr_d == '0) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gauss3x3_seq_ctrl.sv
// ============================================================================
// Module   : tb_gauss3x3_seq_ctrl
// Brief    : Directed self-checking bench for gauss3x3_seq_ctrl (4x4/DP2 and
//            3x3/DP1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gauss3x3_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_start, a_approx, a_pix_valid, a_pix_ready, a_out_ready, a_out_valid;
  logic       a_lb_wr_en, a_dp_en, a_win_load, a_approx_sel, a_busy, a_frame_done;
  logic [9:0] a_lb_col;
  logic       b_start, b_approx, b_pix_valid, b_pix_ready, b_out_ready, b_out_valid;
  logic       b_lb_wr_en, b_dp_en, b_win_load, b_approx_sel, b_busy, b_frame_done;
  logic [9:0] b_lb_col;

  always #5 clk = ~clk;

  gauss3x3_seq_ctrl #(.IMG_W(4), .IMG_H(4), .DP_LAT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .approx_mode(a_approx),
    .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .out_ready(a_out_ready),
    .out_valid(a_out_valid), .lb_wr_en(a_lb_wr_en), .lb_col(a_lb_col),
    .dp_en(a_dp_en), .win_load(a_win_load), .approx_sel(a_approx_sel),
    .busy(a_busy), .frame_done(a_frame_done)
  );

  gauss3x3_seq_ctrl #(.IMG_W(3), .IMG_H(3), .DP_LAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .approx_mode(b_approx),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .out_ready(b_out_ready),
    .out_valid(b_out_valid), .lb_wr_en(b_lb_wr_en), .lb_col(b_lb_col),
    .dp_en(b_dp_en), .win_load(b_win_load), .approx_sel(b_approx_sel),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Event recorders, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          acc_a, out_a, fd_a, fd_cyc_a, last_acc_a;
  logic [31:0] wl_mask_a;
  int          wl_cyc_a[$];
  int          ov_cyc_a[$];
  int          acc_b, out_b, fd_b, fd_cyc_b, last_acc_b;
  logic [31:0] wl_mask_b;
  int          wl_cyc_b[$];
  int          ov_cyc_b[$];

  always @(negedge clk) begin
    if (a_lb_wr_en) begin
      check_eq("a_lb_col", 32'(a_lb_col), 32'(acc_a % 4));
      if (a_win_load && acc_a < 32) begin
        wl_mask_a[acc_a] = 1'b1;
        wl_cyc_a.push_back(cyc);
      end
      acc_a++;
      last_acc_a = cyc;
    end
    if (a_out_valid && a_out_ready) begin
      out_a++;
      ov_cyc_a.push_back(cyc);
    end
    if (a_frame_done) begin
      fd_a++;
      fd_cyc_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (b_lb_wr_en) begin
      check_eq("b_lb_col", 32'(b_lb_col), 32'(acc_b % 3));
      if (b_win_load && acc_b < 32) begin
        wl_mask_b[acc_b] = 1'b1;
        wl_cyc_b.push_back(cyc);
      end
      acc_b++;
      last_acc_b = cyc;
    end
    if (b_out_valid && b_out_ready) begin
      out_b++;
      ov_cyc_b.push_back(cyc);
    end
    if (b_frame_done) begin
      fd_b++;
      fd_cyc_b = cyc;
    end
  end

  task automatic clear_a();
    acc_a = 0; out_a = 0; fd_a = 0; wl_mask_a = '0;
    wl_cyc_a.delete(); ov_cyc_a.delete();
  endtask

  task automatic start_a(input logic mode);
    a_start = 1'b1;
    a_approx = mode;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a();
    logic seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = a_frame_done;
    end
    check_eq("a_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_acc_a(input int n);
    for (int k = 0; k < 200 && acc_a < n; k++) begin
      @(posedge clk); #1;
    end
    check_eq("a_acc_reached", 32'(acc_a >= n), 32'd1);
  endtask

  // Expected 4x4 frame: 16 accepts, windows at accepts 10,11,14,15.
  task automatic check_frame_a(input string tag, input logic lat_chk);
    check_eq({tag, "_accepts"}, 32'(acc_a), 32'd16);
    check_eq({tag, "_wl_mask"}, wl_mask_a, 32'h0000_CC00);
    check_eq({tag, "_outputs"}, 32'(out_a), 32'd4);
    check_eq({tag, "_done_pulses"}, 32'(fd_a), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(a_busy), 32'd0);
    if (lat_chk) begin
      for (int i = 0; i < 4; i++)
        check_eq({tag, "_latency"}, 32'(ov_cyc_a[i] - wl_cyc_a[i]), 32'd2);
      check_eq({tag, "_done_delay"}, 32'(fd_cyc_a - last_acc_a), 32'd3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   col0, acc0;
    logic seen;
    rst_n = 1'b0;
    a_start = 1'b1; a_approx = 1'b1; a_pix_valid = 1'b0; a_out_ready = 1'b1;
    b_start = 1'b0; b_approx = 1'b0; b_pix_valid = 1'b0; b_out_ready = 1'b1;
    clear_a();
    acc_b = 0; out_b = 0; fd_b = 0; wl_mask_b = '0;

    // Reset, with start asserted on the same edges
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(a_busy), 32'd0);
    check_eq("rst_pix_ready", 32'(a_pix_ready), 32'd0);
    check_eq("rst_lb_wr_en", 32'(a_lb_wr_en), 32'd0);
    check_eq("rst_win_load", 32'(a_win_load), 32'd0);
    check_eq("rst_dp_en", 32'(a_dp_en), 32'd1);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_approx_sel", 32'(a_approx_sel), 32'd0);
    check_eq("rst_frame_done", 32'(a_frame_done), 32'd0);
    check_eq("rst_lb_col", 32'(a_lb_col), 32'd0);
    check_eq("rst_b_busy", 32'(b_busy), 32'd0);
    a_start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame, approximate mode, no back-pressure
    a_pix_valid = 1'b1;
    clear_a();
    start_a(1'b1);
    check_eq("f1_busy", 32'(a_busy), 32'd1);
    wait_done_a();
    check_frame_a("f1", 1'b1);
    check_eq("f1_approx_sel", 32'(a_approx_sel), 32'd1);

    // Output stall for 5 cycles after the first output
    clear_a();
    start_a(1'b1);
    for (int k = 0; k < 100 && out_a < 1; k++) begin
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;
    col0 = int'(a_lb_col);
    acc0 = acc_a;
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_pix_ready", 32'(a_pix_ready), 32'd0);
      check_eq("stall_dp_en", 32'(a_dp_en), 32'd0);
      check_eq("stall_out_valid", 32'(a_out_valid), 32'd1);
      check_eq("stall_col", 32'(a_lb_col), 32'(col0));
      @(posedge clk); #1;
    end
    check_eq("stall_accepts_frozen", 32'(acc_a), 32'(acc0));
    a_out_ready = 1'b1;
    wait_done_a();
    check_frame_a("f2", 1'b0);

    // Toggling pix_valid
    clear_a();
    start_a(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      a_pix_valid = (k % 2 == 0);
      @(negedge clk);
      seen = a_frame_done;
      @(posedge clk); #1;
    end
    check_eq("f3_done_seen", 32'(seen), 32'd1);
    a_pix_valid = 1'b1;
    check_frame_a("f3", 1'b1);

    // Reset mid-frame after the 12th accept, then a clean exact-mode frame
    clear_a();
    start_a(1'b1);
    wait_acc_a(12);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_busy", 32'(a_busy), 32'd0);
    check_eq("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("mid_rst_pix_ready", 32'(a_pix_ready), 32'd0);
    check_eq("mid_rst_approx_sel", 32'(a_approx_sel), 32'd0);
    clear_a();
    start_a(1'b0);
    wait_done_a();
    check_frame_a("f4", 1'b1);
    check_eq("f4_approx_sel", 32'(a_approx_sel), 32'd0);

    // start during RUN is ignored
    clear_a();
    start_a(1'b1);
    wait_acc_a(8);
    a_start = 1'b1;
    a_approx = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b0;
    check_eq("f5_sel_hold", 32'(a_approx_sel), 32'd1);
    check_eq("f5_busy", 32'(a_busy), 32'd1);
    wait_done_a();
    check_frame_a("f5", 1'b1);
    check_eq("f5_approx_sel", 32'(a_approx_sel), 32'd1);

    // 3x3 frame with single-stage datapath
    b_pix_valid = 1'b1;
    b_start = 1'b1;
    b_approx = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = b_frame_done;
    end
    check_eq("b_done_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check_eq("b_accepts", 32'(acc_b), 32'd9);
    check_eq("b_wl_mask", wl_mask_b, 32'h0000_0100);
    check_eq("b_outputs", 32'(out_b), 32'd1);
    check_eq("b_latency", 32'(ov_cyc_b[0] - wl_cyc_b[0]), 32'd1);
    check_eq("b_done_delay", 32'(fd_cyc_b - last_acc_b), 32'd2);
    check_eq("b_done_pulses", 32'(fd_b), 32'd1);
    check_eq("b_approx_sel", 32'(b_approx_sel), 32'd1);
    check_eq("b_busy_after", 32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
